// File: rtl/mw_pkg.sv
// -----------------------------------------------------------------------------
// mw_pkg
// Shared definitions for the microwave controller slice.
//   state_t               : controller FSM state encoding (also driven out on
//                           state_out for the debug/status display)
//   DEFAULT_TICKS_PER_SEC : clock cycles per one-second count-enable pulse
//   DEFAULT_MAX_DIGITS    : keypad digits accepted per entry (m, s10, s1)
//   BCD_MAX               : largest legal keypad digit
//   is_bcd()              : true when a keypad code is a decimal digit
// -----------------------------------------------------------------------------
package mw_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ENTRY = 3'd1,
      S_COOK  = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int         DEFAULT_TICKS_PER_SEC = 100;
   localparam int         DEFAULT_MAX_DIGITS    = 3;
   localparam logic [3:0] BCD_MAX               = 4'd9;

   // Keypad codes 10..15 come from the non-digit keys and must never reach
   // the timer's shift chain.
   function automatic logic is_bcd(input logic [3:0] digit);
      return (digit <= BCD_MAX);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Modulo-MODULUS counter that produces a one-cycle pulse each time it wraps.
// Used by the microwave controller to turn the system clock into the timer's
// one-second count enable.
//   clock  : in  system clock, rising edge
//   clear  : in  synchronous clear; count returns to 0, pulse suppressed
//   enable : in  advance the count this cycle; when low the count freezes
//                in place so a paused cook resumes mid-second
//   wrap   : out registered pulse, high for the cycle after the count steps
//                from MODULUS-1 back to 0
// -----------------------------------------------------------------------------
module tick_gen #(
   parameter int MODULUS = 100
) (
   input  logic clock,
   input  logic clear,
   input  logic enable,
   output logic wrap
);

   // A modulus of 1 still needs a one-bit register; it simply wraps on every
   // enabled cycle.
   localparam int               CNT_W    = (MODULUS > 1) ? $clog2(MODULUS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MODULUS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] count;

   // Count register and wrap pulse. Clear wins over enable so a restart
   // never emits a stray pulse. The pulse is registered alongside the count
   // so it leaves the block glitch-free.
   always_ff @(posedge clock) begin
      if (clear) begin
         count <= '0;
         wrap  <= 1'b0;
      end else if (enable) begin
         if (count == CNT_LAST) begin
            count <= '0;
            wrap  <= 1'b1;
         end else begin
            count <= count + CNT_ONE;
            wrap  <= 1'b0;
         end
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule

// File: rtl/microwave_controller.sv
// -----------------------------------------------------------------------------
// microwave_controller
// Sequencing FSM between the keypad/button front end and the BCD countdown
// timer. Shifts keypad digits into the timer, issues the 1 Hz count enable
// while cooking, gates the magnetron on door state and start/stop, and flags
// completion when the timer reaches zero.
//
// Ports
//   clock        in   system clock, all logic on the rising edge
//   clear        in   synchronous active-high reset, beats every other input
//   key_valid    in   one-cycle strobe qualifying key_digit
//   key_digit    in   [3:0] keypad code (0..9 are digits)
//   start        in   one-cycle start-button pulse
//   stop         in   one-cycle stop/cancel pulse
//   door_closed  in   level, 1 = door closed
//   timer_zero   in   timer reports 0:00
//   timer_data   out  [3:0] digit presented to the timer shift input
//   timer_loadn  out  active-low shift strobe to the timer
//   timer_clearn out  active-low clear to the timer
//   timer_en     out  one-cycle count-enable pulse to the timer
//   mag_on       out  magnetron enable
//   done         out  cook-complete indicator
//   state_out    out  [2:0] current FSM state encoding
//
// Every output is a register, so each reacts one clock after the input that
// caused it. mag_on and done are decoded from the next state, which makes them
// track state_out exactly.
// -----------------------------------------------------------------------------
module microwave_controller
   import mw_pkg::*;
#(
   parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
   parameter int MAX_DIGITS    = DEFAULT_MAX_DIGITS
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       start,
   input  logic       stop,
   input  logic       door_closed,
   input  logic       timer_zero,
   output logic [3:0] timer_data,
   output logic       timer_loadn,
   output logic       timer_clearn,
   output logic       timer_en,
   output logic       mag_on,
   output logic       done,
   output logic [2:0] state_out
);

   localparam int                DCNT_W      = $clog2(MAX_DIGITS + 1);
   localparam logic [DCNT_W-1:0] DIGIT_LIMIT = DCNT_W'(MAX_DIGITS);
   localparam logic [DCNT_W-1:0] DIGIT_ONE   = DCNT_W'(1);

   state_t            state;
   state_t            state_next;
   logic [DCNT_W-1:0] digit_cnt;
   logic [DCNT_W-1:0] digit_cnt_next;
   logic [3:0]        data_next;
   logic              loadn_next;
   logic              clearn_next;
   logic              tick_restart;
   logic              tick_enable;
   logic              door_q;
   logic              digit_ok;
   logic              door_fell;

   assign digit_ok  = key_valid && is_bcd(key_digit);
   assign door_fell = door_q && !door_closed;
   assign state_out = state;

   // Next-state and next-output decode. Strobes default to inactive so a
   // loadn or clearn pulse lasts exactly one cycle. Loads only happen on the
   // way into ENTRY and clears only on the way into IDLE, so the timer never
   // sees loadn and clearn low together, and neither can coincide with a
   // count enable (which only fires while staying in COOK).
   always_comb begin
      state_next     = state;
      digit_cnt_next = digit_cnt;
      data_next      = timer_data;
      loadn_next     = 1'b1;
      clearn_next    = 1'b1;
      tick_restart   = 1'b0;

      case (state)
         S_IDLE: begin
            if (digit_ok) begin
               data_next      = key_digit;
               loadn_next     = 1'b0;
               digit_cnt_next = DIGIT_ONE;
               state_next     = S_ENTRY;
            end
         end

         // Buttons take precedence over a digit arriving in the same cycle.
         // A zero timer means nothing was entered worth cooking.
         S_ENTRY: begin
            if (stop) begin
               clearn_next    = 1'b0;
               digit_cnt_next = '0;
               state_next     = S_IDLE;
            end else if (start && door_closed && !timer_zero) begin
               tick_restart = 1'b1;
               state_next   = S_COOK;
            end else if (digit_ok && (digit_cnt < DIGIT_LIMIT)) begin
               data_next      = key_digit;
               loadn_next     = 1'b0;
               digit_cnt_next = digit_cnt + DIGIT_ONE;
            end
         end

         // Reaching zero wins over a simultaneous door-open or stop so the
         // user still gets the completion indication.
         S_COOK: begin
            if (timer_zero) begin
               state_next = S_DONE;
            end else if (!door_closed || stop) begin
               state_next = S_PAUSE;
            end
         end

         // Stop is checked first so a start+stop together cancels.
         S_PAUSE: begin
            if (stop) begin
               clearn_next    = 1'b0;
               digit_cnt_next = '0;
               state_next     = S_IDLE;
            end else if (start && door_closed) begin
               state_next = S_COOK;
            end
         end

         // Any user interaction acknowledges completion. A key press here is
         // consumed as the acknowledgement and is not shifted into the timer.
         S_DONE: begin
            if (key_valid || start || stop || door_fell) begin
               clearn_next    = 1'b0;
               digit_cnt_next = '0;
               state_next     = S_IDLE;
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // The one-second counter only advances while cooking continues; leaving
   // COOK freezes it so a resume after PAUSE finishes the partial second.
   assign tick_enable = (state == S_COOK) && (state_next == S_COOK);

   // State and registered outputs. Reset leaves the timer being cleared in
   // the first cycle after clear, with every other strobe idle. The door is
   // registered once purely for 1->0 edge detection in DONE.
   always_ff @(posedge clock) begin
      if (clear) begin
         state        <= S_IDLE;
         digit_cnt    <= '0;
         timer_data   <= 4'd0;
         timer_loadn  <= 1'b1;
         timer_clearn <= 1'b0;
         mag_on       <= 1'b0;
         done         <= 1'b0;
         door_q       <= 1'b0;
      end else begin
         state        <= state_next;
         digit_cnt    <= digit_cnt_next;
         timer_data   <= data_next;
         timer_loadn  <= loadn_next;
         timer_clearn <= clearn_next;
         mag_on       <= (state_next == S_COOK);
         done         <= (state_next == S_DONE);
         door_q       <= door_closed;
      end
   end

   tick_gen #(
      .MODULUS (TICKS_PER_SEC)
   ) u_tick_gen (
      .clock  (clock),
      .clear  (clear || tick_restart),
      .enable (tick_enable),
      .wrap   (timer_en)
   );

endmodule

// File: tb/tb_microwave_controller.sv
// -----------------------------------------------------------------------------
// tb_microwave_controller
// Scoreboard bench for microwave_controller with a one-second period of four
// clocks. Stimulus code pushes the expected output events (clear pulse, state
// change, digit load, count enable) tagged with the cycle they must appear in;
// a monitor on the falling edge observes the DUT and pops/compares in order.
// A small behavioural BCD timer closes the loop so timer_zero behaves like
// the real counter.
// -----------------------------------------------------------------------------
module tb_microwave_controller;

   localparam int TPS = 4;

   localparam int EV_CLEAR = 0;
   localparam int EV_STATE = 1;
   localparam int EV_LOAD  = 2;
   localparam int EV_TICK  = 3;

   // Event payloads written out by hand from the required behaviour.
   // clear : {0, state[2:0], mag_on, done, timer_en, timer_loadn}
   // state : {0, state[2:0], mag_on, done, 2'b00}
   // tick  : {00000, state[2:0]}
   localparam logic [7:0] V_CLR   = 8'h01;
   localparam logic [7:0] V_IDLE  = 8'h00;
   localparam logic [7:0] V_ENTRY = 8'h10;
   localparam logic [7:0] V_COOK  = 8'h28;
   localparam logic [7:0] V_PAUSE = 8'h30;
   localparam logic [7:0] V_DONE  = 8'h44;
   localparam logic [7:0] V_TICK  = 8'h02;

   typedef struct {
      int         at_cyc;
      int         kind;
      logic [7:0] val;
   } exp_t;

   logic       clock = 1'b0;
   logic       clear;
   logic       key_valid;
   logic [3:0] key_digit;
   logic       start;
   logic       stop;
   logic       door_closed;
   logic       timer_zero;
   logic [3:0] timer_data;
   logic       timer_loadn;
   logic       timer_clearn;
   logic       timer_en;
   logic       mag_on;
   logic       done;
   logic [2:0] state_out;

   int   cyc = 0;
   int   n_compared = 0;
   int   n_mismatched = 0;
   int   c0;
   int   p0;
   exp_t exp_q[$];
   logic [4:0] prev_obs = 5'd0;

   logic [3:0] t_min;
   logic [3:0] t_ten;
   logic [3:0] t_one;

   microwave_controller #(
      .TICKS_PER_SEC (TPS),
      .MAX_DIGITS    (3)
   ) dut (
      .clock        (clock),
      .clear        (clear),
      .key_valid    (key_valid),
      .key_digit    (key_digit),
      .start        (start),
      .stop         (stop),
      .door_closed  (door_closed),
      .timer_zero   (timer_zero),
      .timer_data   (timer_data),
      .timer_loadn  (timer_loadn),
      .timer_clearn (timer_clearn),
      .timer_en     (timer_en),
      .mag_on       (mag_on),
      .done         (done),
      .state_out    (state_out)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Behavioural m:ss BCD timer: clear, shift-in, or count down one second.
   always @(posedge clock) begin
      if (!timer_clearn) begin
         t_min <= 4'd0;
         t_ten <= 4'd0;
         t_one <= 4'd0;
      end else if (!timer_loadn) begin
         t_min <= t_ten;
         t_ten <= t_one;
         t_one <= timer_data;
      end else if (timer_en) begin
         if (t_one != 4'd0) begin
            t_one <= t_one - 4'd1;
         end else if (t_ten != 4'd0) begin
            t_ten <= t_ten - 4'd1;
            t_one <= 4'd9;
         end else if (t_min != 4'd0) begin
            t_min <= t_min - 4'd1;
            t_ten <= 4'd5;
            t_one <= 4'd9;
         end
      end
   end

   assign timer_zero = (t_min == 4'd0) && (t_ten == 4'd0) && (t_one == 4'd0);

   function automatic string kind_name(input int kind);
      case (kind)
         EV_CLEAR: return "clear_pulse";
         EV_STATE: return "state_change";
         EV_LOAD:  return "digit_load";
         default:  return "count_enable";
      endcase
   endfunction

   // Insert an expectation keeping the queue ordered by (cycle, kind), the
   // same order in which the monitor observes events.
   task automatic checkOutput(input int kind, input int at_cyc, input logic [7:0] val);
      exp_t e;
      int   pos;
      e.at_cyc = at_cyc;
      e.kind   = kind;
      e.val    = val;
      pos = exp_q.size();
      while (pos > 0 && (exp_q[pos-1].at_cyc * 4 + exp_q[pos-1].kind) > (at_cyc * 4 + kind))
         pos--;
      exp_q.insert(pos, e);
   endtask

   task automatic report_missing();
      exp_t e;
      e = exp_q.pop_front();
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s @cycle %0d: actual=none required=%02h",
               kind_name(e.kind), e.at_cyc, e.val);
   endtask

   task automatic observe(input int kind, input logic [7:0] val);
      exp_t e;
      int   key;
      key = cyc * 4 + kind;
      while (exp_q.size() > 0 && (exp_q[0].at_cyc * 4 + exp_q[0].kind) < key)
         report_missing();
      n_compared++;
      if (exp_q.size() > 0 && (exp_q[0].at_cyc * 4 + exp_q[0].kind) == key) begin
         e = exp_q.pop_front();
         if (e.val !== val) begin
            n_mismatched++;
            $display("[TB] FAIL %s @cycle %0d: actual=%02h required=%02h",
                     kind_name(kind), cyc, val, e.val);
         end
      end else begin
         n_mismatched++;
         $display("[TB] FAIL %s @cycle %0d: actual=%02h required=none",
                  kind_name(kind), cyc, val);
      end
   endtask

   task automatic flush_due(input int limit);
      while (exp_q.size() > 0 && exp_q[0].at_cyc <= limit)
         report_missing();
   endtask

   // Monitor: sample away from the active edge and turn output activity into
   // events for the scoreboard.
   always @(negedge clock) begin
      if (cyc > 0) begin
         if (!timer_clearn)
            observe(EV_CLEAR, {1'b0, state_out, mag_on, done, timer_en, timer_loadn});
         if ({state_out, mag_on, done} !== prev_obs)
            observe(EV_STATE, {1'b0, state_out, mag_on, done, 2'b00});
         if (!timer_loadn)
            observe(EV_LOAD, {4'h0, timer_data});
         if (timer_en)
            observe(EV_TICK, {5'd0, state_out});
         prev_obs = {state_out, mag_on, done};
         flush_due(cyc);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target)
         tick();
   endtask

   // Present one cycle of strobes; they are sampled on the next edge and the
   // response is visible in cycle cyc+1 as seen before the call.
   task automatic applyStimulus(input logic kv, input logic [3:0] dig,
                                input logic st, input logic sp);
      key_valid = kv;
      key_digit = dig;
      start     = st;
      stop      = sp;
      tick();
      key_valid = 1'b0;
      key_digit = 4'd0;
      start     = 1'b0;
      stop      = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog @cycle %0d: actual=running required=finished", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      clear       = 1'b1;
      key_valid   = 1'b0;
      key_digit   = 4'd0;
      start       = 1'b0;
      stop        = 1'b0;
      door_closed = 1'b1;

      $display("[TB] reset");
      checkOutput(EV_CLEAR, 1, V_CLR);
      tick();
      clear = 1'b0;

      $display("[TB] digit entry 8,5,7 then overflow and invalid keys");
      checkOutput(EV_LOAD, cyc + 1, 8'h08);
      checkOutput(EV_STATE, cyc + 1, V_ENTRY);
      applyStimulus(1'b1, 4'd8, 1'b0, 1'b0);
      checkOutput(EV_LOAD, cyc + 1, 8'h05);
      applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
      checkOutput(EV_LOAD, cyc + 1, 8'h07);
      applyStimulus(1'b1, 4'd7, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd2, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd12, 1'b0, 1'b0);
      door_closed = 1'b0;
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
      door_closed = 1'b1;
      tick();
      checkOutput(EV_CLEAR, cyc + 1, V_CLR);
      checkOutput(EV_STATE, cyc + 1, V_IDLE);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      applyStimulus(1'b1, 4'd12, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
      tick();

      $display("[TB] cook 0:03 to completion");
      checkOutput(EV_LOAD, cyc + 1, 8'h00);
      checkOutput(EV_STATE, cyc + 1, V_ENTRY);
      applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
      checkOutput(EV_LOAD, cyc + 1, 8'h00);
      applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
      checkOutput(EV_LOAD, cyc + 1, 8'h03);
      applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
      tick();
      c0 = cyc + 1;
      checkOutput(EV_STATE, c0, V_COOK);
      checkOutput(EV_TICK, c0 + 4, V_TICK);
      checkOutput(EV_TICK, c0 + 8, V_TICK);
      checkOutput(EV_TICK, c0 + 12, V_TICK);
      checkOutput(EV_STATE, c0 + 14, V_DONE);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
      wait_until(c0 + 17);
      checkOutput(EV_CLEAR, cyc + 1, V_CLR);
      checkOutput(EV_STATE, cyc + 1, V_IDLE);
      applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
      tick();

      $display("[TB] door open pauses, resume finishes partial second");
      checkOutput(EV_LOAD, cyc + 1, 8'h01);
      checkOutput(EV_STATE, cyc + 1, V_ENTRY);
      applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
      checkOutput(EV_LOAD, cyc + 1, 8'h00);
      applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
      tick();
      c0 = cyc + 1;
      checkOutput(EV_STATE, c0, V_COOK);
      checkOutput(EV_TICK, c0 + 4, V_TICK);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
      wait_until(c0 + 6);
      door_closed = 1'b0;
      checkOutput(EV_STATE, cyc + 1, V_PAUSE);
      tick();
      repeat (5) tick();
      door_closed = 1'b1;
      p0 = cyc;
      checkOutput(EV_STATE, p0 + 1, V_COOK);
      checkOutput(EV_TICK, p0 + 3, V_TICK);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);

      $display("[TB] stop pauses, second stop cancels");
      wait_until(p0 + 5);
      checkOutput(EV_STATE, cyc + 1, V_PAUSE);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      repeat (3) tick();
      checkOutput(EV_CLEAR, cyc + 1, V_CLR);
      checkOutput(EV_STATE, cyc + 1, V_IDLE);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      tick();

      $display("[TB] clear during cook");
      checkOutput(EV_LOAD, cyc + 1, 8'h09);
      checkOutput(EV_STATE, cyc + 1, V_ENTRY);
      applyStimulus(1'b1, 4'd9, 1'b0, 1'b0);
      tick();
      c0 = cyc + 1;
      checkOutput(EV_STATE, c0, V_COOK);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
      tick();
      tick();
      clear = 1'b1;
      checkOutput(EV_CLEAR, cyc + 1, V_CLR);
      checkOutput(EV_STATE, cyc + 1, V_IDLE);
      tick();
      clear = 1'b0;
      tick();

      $display("[TB] timer zero and stop together, door edge acknowledges");
      checkOutput(EV_LOAD, cyc + 1, 8'h01);
      checkOutput(EV_STATE, cyc + 1, V_ENTRY);
      applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
      tick();
      c0 = cyc + 1;
      checkOutput(EV_STATE, c0, V_COOK);
      checkOutput(EV_TICK, c0 + 4, V_TICK);
      checkOutput(EV_STATE, c0 + 6, V_DONE);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
      wait_until(c0 + 5);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      wait_until(c0 + 8);
      door_closed = 1'b0;
      checkOutput(EV_CLEAR, cyc + 1, V_CLR);
      checkOutput(EV_STATE, cyc + 1, V_IDLE);
      tick();
      door_closed = 1'b1;
      repeat (4) tick();

      @(negedge clock);
      #1;
      flush_due(32'h7fff_ffff);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
